// File: rtl/jk_sync_down_counter.sv
// jk_sync_down_counter
//   Synchronous modulo-MODULUS down counter built from JK toggle cells.
//   Counts MODULUS-1 down to 0, with parallel load (clamped to MODULUS-1),
//   count enable, a combinational zero flag and a registered borrow pulse
//   that is coincident with the wrapped value. All state changes happen on
//   the falling edge of clk; rst clears everything asynchronously.
//
//   Optional feature, selected by the macro DOWN_CNT_ONESHOT_EN:
//     defined   - one-shot mode: counting stops at 0 and sets done, which
//                 holds until a load or reset; en is ignored while done=1.
//     undefined - free-running wrap to MODULUS-1 with borrow; done tied 0.
module jk_sync_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  // Largest legal count; also the wrap target and the load clamp value.
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] jk_next;
  logic             cnt_zero;

`ifdef DOWN_CNT_ONESHOT_EN
  logic done_q, done_d;
`endif

  assign cnt_zero = (cnt_q == '0);

  // Toggle chain: bit i toggles when enabled and every lower bit is 0,
  // which is the down-count rule T[i] = en & (q[i-1:0] == 0).
  always_comb begin
    toggle[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & ~cnt_q[i-1];
    end
  end

  // JK cells with J = K = T: set when 0 and T, keep when 1 and not T.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jk_next[i] = (toggle[i] & ~cnt_q[i]) | (~toggle[i] & cnt_q[i]);
    end
  end

  // Next-state selection with priority load > en > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    cnt_d    = cnt_q;
    borrow_d = 1'b0;
`ifdef DOWN_CNT_ONESHOT_EN
    done_d   = done_q;
`endif
    if (load) begin
      cnt_d = (din > MOD_MAX) ? MOD_MAX : din;
`ifdef DOWN_CNT_ONESHOT_EN
      done_d = 1'b0;
`endif
    end else if (en) begin
`ifdef DOWN_CNT_ONESHOT_EN
      // Terminal count parks at 0 and raises done; en is dead once done.
      if (!done_q) begin
        if (cnt_zero) begin
          done_d = 1'b1;
        end else begin
          cnt_d = jk_next;
        end
      end
`else
      // Modulus wrap overrides the toggle result at 0 (identical to it
      // when MODULUS == 2**WIDTH).
      if (cnt_zero) begin
        cnt_d    = MOD_MAX;
        borrow_d = 1'b1;
      end else begin
        cnt_d = jk_next;
      end
`endif
    end
  end

  // State registers: falling-edge clocked, asynchronously cleared by rst.
  always_ff @(negedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef DOWN_CNT_ONESHOT_EN
  // One-shot terminal flag register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  assign q      = cnt_q;
  assign zero   = cnt_zero;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_jk_sync_down_counter.sv
// tb_jk_sync_down_counter
//   Directed bench for jk_sync_down_counter. Two instances: dut_a with the
//   default WIDTH=4/MODULUS=16 and dut_b with MODULUS=10 for clamp and
//   non-power-of-two wrap. Expected values are hand-computed; the one-shot
//   variants are selected when DOWN_CNT_ONESHOT_EN is defined.
module tb_jk_sync_down_counter;

`ifdef DOWN_CNT_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en_a, load_a, en_b, load_b;
  logic [3:0] din_a, din_b;
  logic [3:0] q_a, q_b;
  logic       zero_a, borrow_a, done_a;
  logic       zero_b, borrow_b, done_b;

  int total_cnt  = 0;
  int passed_cnt = 0;

  jk_sync_down_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .load(load_a), .din(din_a),
    .q(q_a), .zero(zero_a), .borrow(borrow_a), .done(done_a)
  );

  jk_sync_down_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .din(din_b),
    .q(q_b), .zero(zero_b), .borrow(borrow_b), .done(done_b)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "time limit expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) passed_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input int eq, input bit eb, input bit ed);
    check({tag, ".q"},      32'(q_a),      32'(eq));
    check({tag, ".zero"},   32'(zero_a),   32'(eq == 0));
    check({tag, ".borrow"}, 32'(borrow_a), 32'(eb));
    check({tag, ".done"},   32'(done_a),   32'(ed));
  endtask

  task automatic chk_b(input string tag, input int eq, input bit eb, input bit ed);
    check({tag, ".q"},      32'(q_b),      32'(eq));
    check({tag, ".zero"},   32'(zero_b),   32'(eq == 0));
    check({tag, ".borrow"}, 32'(borrow_b), 32'(eb));
    check({tag, ".done"},   32'(done_b),   32'(ed));
  endtask

  // Advance one active (falling) edge and settle away from it.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b0; load_a = 1'b0; din_a = '0;
    en_b = 1'b0; load_b = 1'b0; din_b = '0;
    #1;
    chk_a("reset_a", 0, 0, 0);
    chk_b("reset_b", 0, 0, 0);
    #11 rst = 1'b0;

    // Load 3 then count down through the wrap.
    load_a = 1'b1; din_a = 4'd3;
    tick(); chk_a("load3", 3, 0, 0);
    load_a = 1'b0; en_a = 1'b1;
    tick(); chk_a("dn2", 2, 0, 0);
    tick(); chk_a("dn1", 1, 0, 0);
    tick(); chk_a("dn0", 0, 0, 0);
    tick(); chk_a("wrap15", ONESHOT ? 0 : 15, !ONESHOT, ONESHOT);
    tick(); chk_a("dn14", ONESHOT ? 0 : 14, 0, ONESHOT);

    // Asynchronous reset between edges while q=5.
    load_a = 1'b1; en_a = 1'b0; din_a = 4'd5;
    tick(); chk_a("load5", 5, 0, 0);
    load_a = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk_a("rst_mid_a", 0, 0, 0);
    chk_b("rst_mid_b", 0, 0, 0);
    rst = 1'b0;
    tick(); chk_a("post_rst_hold", 0, 0, 0);

    // load and en together at q=0: load wins, no borrow.
    load_a = 1'b1; en_a = 1'b1; din_a = 4'd7;
    tick(); chk_a("load_over_en", 7, 0, 0);
    load_a = 1'b0;
    tick(); chk_a("cnt6", 6, 0, 0);
    tick(); chk_a("cnt5", 5, 0, 0);
    tick(); chk_a("cnt4", 4, 0, 0);

    // Hold with en=0, then alternate en.
    load_a = 1'b1; en_a = 1'b0; din_a = 4'd6;
    tick(); chk_a("load6", 6, 0, 0);
    load_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a("hold6", 6, 0, 0);
    end
    en_a = 1'b1; tick(); chk_a("alt_en1", 5, 0, 0);
    en_a = 1'b0; tick(); chk_a("alt_en0", 5, 0, 0);
    en_a = 1'b1; tick(); chk_a("alt_en1b", 4, 0, 0);
    en_a = 1'b0; tick(); chk_a("alt_en0b", 4, 0, 0);

    // MODULUS=10: clamp on load, boundary load, wrap to 9.
    load_b = 1'b1; din_b = 4'd12;
    tick(); chk_b("clamp12", 9, 0, 0);
    din_b = 4'd10;
    tick(); chk_b("clamp10", 9, 0, 0);
    din_b = 4'd9;
    tick(); chk_b("load9", 9, 0, 0);
    din_b = 4'd0;
    tick(); chk_b("load0", 0, 0, 0);
    load_b = 1'b0; en_b = 1'b1;
    tick(); chk_b("wrap9", ONESHOT ? 0 : 9, !ONESHOT, ONESHOT);
    tick(); chk_b("dn8", ONESHOT ? 0 : 8, 0, ONESHOT);
    load_b = 1'b1; din_b = 4'd4;
    tick(); chk_b("reload4", 4, 0, 0);
    load_b = 1'b0; en_b = 1'b0;

    // Terminal behaviour from load 2 (one-shot parks at 0 with done).
    load_a = 1'b1; din_a = 4'd2;
    tick(); chk_a("load2", 2, 0, 0);
    load_a = 1'b0; en_a = 1'b1;
    tick(); chk_a("os1", 1, 0, 0);
    tick(); chk_a("os0", 0, 0, 0);
    tick(); chk_a("os_term", ONESHOT ? 0 : 15, !ONESHOT, ONESHOT);
    tick(); chk_a("os_stay", ONESHOT ? 0 : 14, 0, ONESHOT);
    load_a = 1'b1; din_a = 4'd4;
    tick(); chk_a("os_reload", 4, 0, 0);
    load_a = 1'b0; en_a = 1'b0;

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
